// File: rtl/seven_seg_scan.sv
// ---------------------------------------------------------------------------
// seven_seg_scan
//   Time-multiplexed N-digit hex seven-segment driver.
//   A load strobe captures a packed value into a shadow buffer. The shadow is
//   copied into the display registers only at a frame boundary, so a frame
//   never shows a mix of old and new digits. A prescaler sets the length of
//   each digit slot. Each slot ends with one dead cycle that blanks the digit
//   enables, which stops the next digit ghosting onto the previous one.
//
// Parameters
//   N_DIGITS      number of digits scanned (1..8)
//   PRESCALE      clk cycles per digit slot (>= 2)
//   COMMON_ANODE  0: outputs active-high; 1: seg_out/dp_out/dig_sel inverted
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   load      in   capture value/dp_in on this edge
//   value     in   packed nibbles, digit 0 = value[3:0]
//   dp_in     in   decimal point per digit
//   seg_out   out  segments {g,f,e,d,c,b,a}, registered
//   dp_out    out  decimal point of the lit digit, registered
//   dig_sel   out  one-hot digit enable, registered
//   upd_pend  out  shadow holds a load not yet displayed
//
// Build option
//   SEVEN_SEG_LZB_EN  when defined, leading-zero blanking is built. Digits
//                     above the most-significant nonzero nibble show no
//                     segments. Digit 0 always shows.
// ---------------------------------------------------------------------------
module seven_seg_scan #(
    parameter int N_DIGITS     = 4,
    parameter int PRESCALE     = 1000,
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   dig_sel,
    output logic                  upd_pend
);

    localparam int PC_W  = $clog2(PRESCALE);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [PC_W-1:0]     PC_LAST  = PC_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]          SEG_POL  = {7{COMMON_ANODE}};
    localparam logic [N_DIGITS-1:0] DIG_POL  = {N_DIGITS{COMMON_ANODE}};

    logic [PC_W-1:0]       pc;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] shadow_val;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [4*N_DIGITS-1:0] disp_val;
    logic [N_DIGITS-1:0]   disp_dp;

    logic                  slot_end;
    logic                  frame_end;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic [N_DIGITS-1:0]   dig_hot;
    logic                  blank;
    logic [6:0]            seg_lit;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0111111;
            4'h1:    seg = 7'b0000110;
            4'h2:    seg = 7'b1011011;
            4'h3:    seg = 7'b1001111;
            4'h4:    seg = 7'b1100110;
            4'h5:    seg = 7'b1101101;
            4'h6:    seg = 7'b1111101;
            4'h7:    seg = 7'b0000111;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1101111;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b1111100;
            4'hC:    seg = 7'b0111001;
            4'hD:    seg = 7'b1011110;
            4'hE:    seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
        return seg;
    endfunction

    assign slot_end  = (pc == PC_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= '0;
            idx <= '0;
        end else begin
            if (slot_end) begin
                pc <= '0;
                if (idx == IDX_LAST) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                pc <= pc + 1'b1;
            end
        end
    end

    // Shadow/display double buffer. A load on the boundary edge goes
    // straight into the display regs, so nothing is left pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            upd_pend   <= 1'b0;
        end else begin
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end
            if (frame_end) begin
                disp_val <= load ? value : shadow_val;
                disp_dp  <= load ? dp_in : shadow_dp;
                upd_pend <= 1'b0;
            end else if (load) begin
                upd_pend <= 1'b1;
            end
        end
    end

    // Current digit mux and one-hot enable
    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        dig_hot = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib    = disp_val[4*i +: 4];
                cur_dp     = disp_dp[i];
                dig_hot[i] = 1'b1;
            end
        end
    end

`ifdef SEVEN_SEG_LZB_EN
    // A digit is blank when it and every digit above it are zero.
    // Digit 0 is excluded, so a value of 0 still shows one "0".
    logic nonzero_at_or_above;

    always_comb begin
        nonzero_at_or_above = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if ((IDX_W'(i) >= idx) && (disp_val[4*i +: 4] != 4'h0)) begin
                nonzero_at_or_above = 1'b1;
            end
        end
    end

    assign blank = (idx != '0) && !nonzero_at_or_above;
`else
    assign blank = 1'b0;
`endif

    assign seg_lit = blank ? 7'b0000000 : hex_to_seg(cur_nib);

    // Pin registers hold the pin-level value, so reset can place them
    // directly at the inactive level for either polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= SEG_POL;
            dp_out  <= COMMON_ANODE;
            dig_sel <= DIG_POL;
        end else begin
            seg_out <= seg_lit ^ SEG_POL;
            dp_out  <= cur_dp ^ COMMON_ANODE;
            dig_sel <= (slot_end ? '0 : dig_hot) ^ DIG_POL;
        end
    end

endmodule
